// File: rtl/l2_request_arbiter.sv
// Arbitrates the L1 I-cache and D-cache onto the single L2 port (`ARB_ROUND_ROBIN_EN: alternate on ties).
// Latency: +1 cycle request path (registered capture), 0 cycles response path (combinational route).
// Backpressure: requesters hold read/write until their resp pulse; the loser simply waits in IDLE.
module l2_request_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] icache_address,
    input  logic [LINE_W-1:0] icache_wdata,
    input  logic              icache_read,
    input  logic              icache_write,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    input  logic              dcache_read,
    input  logic              dcache_write,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    output logic              l2_read,
    output logic              l2_write,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t state;

    logic              i_pend;
    logic              d_pend;
    logic              grant_d;
    logic [ADDR_W-1:0] sel_address;
    logic [LINE_W-1:0] sel_wdata;
    logic              sel_read;
    logic              sel_write;

    assign i_pend = icache_read | icache_write;
    assign d_pend = dcache_read | dcache_write;

`ifdef ARB_ROUND_ROBIN_EN
    // Set when the most recent grant went to the I-cache; resets to I so D wins the first tie.
    logic last_i;
    assign grant_d = d_pend & (~i_pend | last_i);
`else
    assign grant_d = d_pend;
`endif

    always_comb begin
        sel_address = icache_address;
        sel_wdata   = icache_wdata;
        sel_read    = icache_read;
        sel_write   = icache_write;
        if (grant_d) begin
            sel_address = dcache_address;
            sel_wdata   = dcache_wdata;
            sel_read    = dcache_read;
            sel_write   = dcache_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            l2_address <= '0;
            l2_wdata   <= '0;
            l2_read    <= 1'b0;
            l2_write   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_i     <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_pend | d_pend) begin
                        l2_address <= sel_address;
                        l2_wdata   <= sel_wdata;
                        // Simultaneous read and write is treated as a write.
                        l2_write   <= sel_write;
                        l2_read    <= sel_read & ~sel_write;
                        state      <= grant_d ? BUSY_D : BUSY_I;
`ifdef ARB_ROUND_ROBIN_EN
                        last_i     <= ~grant_d;
`endif
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (l2_resp) begin
                        l2_read  <= 1'b0;
                        l2_write <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Responses are only forwarded while a transaction is in flight, so l2_resp in IDLE is dropped.
    assign icache_resp  = (state == BUSY_I) & l2_resp;
    assign dcache_resp  = (state == BUSY_D) & l2_resp;
    assign icache_rdata = icache_resp ? l2_rdata : '0;
    assign dcache_rdata = dcache_resp ? l2_rdata : '0;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter; expected values are hand-computed constants.
module tb_l2_request_arbiter;

    logic         clk;
    logic         rst_n;
    logic [15:0]  icache_address, dcache_address, l2_address;
    logic [127:0] icache_wdata, dcache_wdata, icache_rdata, dcache_rdata, l2_wdata, l2_rdata;
    logic         icache_read, icache_write, icache_resp;
    logic         dcache_read, dcache_write, dcache_resp;
    logic         l2_read, l2_write, l2_resp;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] A5  = {16{8'hA5}};
    localparam logic [127:0] DBF = 128'hDEAD_BEEF;

    l2_request_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .icache_address (icache_address),
        .icache_wdata   (icache_wdata),
        .icache_read    (icache_read),
        .icache_write   (icache_write),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .dcache_address (dcache_address),
        .dcache_wdata   (dcache_wdata),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_rdata   (dcache_rdata),
        .dcache_resp    (dcache_resp),
        .l2_address     (l2_address),
        .l2_wdata       (l2_wdata),
        .l2_read        (l2_read),
        .l2_write       (l2_write),
        .l2_rdata       (l2_rdata),
        .l2_resp        (l2_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        icache_address = '0; icache_wdata = '0; icache_read = 0; icache_write = 0;
        dcache_address = '0; dcache_wdata = '0; dcache_read = 0; dcache_write = 0;
        l2_rdata = '0; l2_resp = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    initial begin
        logic exp_d;
        clear_inputs();
        rst_n = 0;
        #3;
        check("rst_l2_read", l2_read, 0);
        check("rst_l2_write", l2_write, 0);
        check("rst_l2_address", l2_address, 0);
        check("rst_l2_wdata", l2_wdata, 0);
        check("rst_resp", {icache_resp, dcache_resp}, 0);
        tick();
        rst_n = 1;
        tick();

        // 1: single I read, L2 answers 3 cycles after the request
        icache_read = 1; icache_address = 16'h1230;
        tick(); #1;
        check("t1_l2_read", l2_read, 1);
        check("t1_l2_address", l2_address, 16'h1230);
        check("t1_rdata_idle", icache_rdata, 0);
        tick();
        tick();
        l2_resp = 1; l2_rdata = A5; #1;
        check("t1_icache_resp", icache_resp, 1);
        check("t1_icache_rdata", icache_rdata, A5);
        check("t1_dcache_resp", dcache_resp, 0);
        check("t1_dcache_rdata", dcache_rdata, 0);
        tick();
        l2_resp = 0; l2_rdata = '0; icache_read = 0; #1;
        check("t1_l2_read_clr", l2_read, 0);
        check("t1_icache_resp_clr", icache_resp, 0);

        // 2: single D write
        do_reset();
        dcache_write = 1; dcache_address = 16'h4000; dcache_wdata = DBF;
        tick(); #1;
        check("t2_l2_write", l2_write, 1);
        check("t2_l2_read", l2_read, 0);
        check("t2_l2_address", l2_address, 16'h4000);
        check("t2_l2_wdata", l2_wdata, DBF);
        tick(); #1;
        check("t2_l2_write_hold", l2_write, 1);
        l2_resp = 1; #1;
        check("t2_dcache_resp", dcache_resp, 1);
        check("t2_icache_resp", icache_resp, 0);
        tick();
        l2_resp = 0; dcache_write = 0; #1;
        check("t2_l2_write_clr", l2_write, 0);
        check("t2_dcache_resp_clr", dcache_resp, 0);

        // 3: tie for 4 back-to-back transactions
        do_reset();
        icache_read = 1; icache_address = 16'h1111;
        dcache_read = 1; dcache_address = 16'h2222;
        for (int n = 0; n < 4; n++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_d = (n % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            tick(); #1;
            check($sformatf("t3_winner_addr%0d", n), l2_address, exp_d ? 16'h2222 : 16'h1111);
            tick();
            l2_resp = 1; #1;
            check($sformatf("t3_resp%0d", n), {icache_resp, dcache_resp}, exp_d ? 2'b01 : 2'b10);
            tick();
            l2_resp = 0;
        end
        icache_read = 0; dcache_read = 0;

        // 4: capture stability while BUSY_D
        do_reset();
        dcache_read = 1; dcache_address = 16'h2468;
        tick();
        dcache_address = 16'hFFFF; dcache_read = 0; #1;
        check("t4_addr_hold0", l2_address, 16'h2468);
        tick(); #1;
        check("t4_addr_hold1", l2_address, 16'h2468);
        check("t4_read_hold", l2_read, 1);
        l2_resp = 1; #1;
        check("t4_dcache_resp", dcache_resp, 1);
        tick();
        l2_resp = 0; #1;
        check("t4_l2_read_clr", l2_read, 0);

        // 5: reset while BUSY_I
        do_reset();
        icache_read = 1; icache_address = 16'h0ABC;
        tick(); #1;
        check("t5_l2_read_pre", l2_read, 1);
        rst_n = 0; #1;
        check("t5_l2_read_rst", l2_read, 0);
        check("t5_l2_address_rst", l2_address, 0);
        icache_read = 0;
        tick();
        rst_n = 1;
        tick();
        l2_resp = 1; l2_rdata = A5; #1;
        check("t5_no_icache_resp", icache_resp, 0);
        check("t5_no_icache_rdata", icache_rdata, 0);
        tick();
        l2_resp = 0; l2_rdata = '0;

        // 6: spurious resp in IDLE, then read+write together
        do_reset();
        l2_resp = 1; l2_rdata = A5; #1;
        check("t6_spurious_resp", {icache_resp, dcache_resp}, 0);
        check("t6_spurious_rdata", dcache_rdata, 0);
        tick();
        l2_resp = 0; l2_rdata = '0;
        icache_read = 1; icache_write = 1; icache_address = 16'h0F0F; icache_wdata = DBF;
        tick(); #1;
        check("t6_l2_write", l2_write, 1);
        check("t6_l2_read", l2_read, 0);
        check("t6_l2_wdata", l2_wdata, DBF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
